ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit for the EX stage of the five-stage MIPS pipeline, with the architectural HI/LO registers. It takes the ID/EX pipeline register's operand and control fields and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. While an operation is in flight it raises a busy flag, which the hazard unit uses to stall the front of the pipeline. HI/LO are exposed directly for MFHI/MFLO.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  EX holds a valid mul/div/mt instruction this cycle
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
- src_a  in  32  rs operand (forwarded data1)
- src_b  in  32  rt operand (forwarded data2)
- flush  in  1  squash the in-flight operation (branch/exception flush of EX)
- busy  out  1  operation in progress; equals (state != IDLE)
- done  out  1  one-cycle pulse: HI/LO were updated by a completed mul/div
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1 and flush=0:
  - MTHI writes hi<=src_a and MTLO writes lo<=src_a at that edge. The state stays IDLE and done stays 0.
  - MULT/MULTU/DIV/DIVU latch the operands and go to MUL or DIV with counter=0.
  - Signed ops latch |src_a| and |src_b|, plus two sign flags: product/quotient sign = a[31]^b[31], remainder sign = a[31].
  - Unsigned ops latch the operands raw with both sign flags cleared.
  - op=000 or 111 does nothing.
- MUL: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first. After 32 iterations go to FIX.
- DIV: restoring division with a 33-bit partial remainder, one quotient bit per cycle, MSB first. After 32 iterations go to FIX.
- FIX, executed in one cycle:
  - Apply sign correction by two's-complement negation: the 64-bit product for MUL; quotient and remainder independently for DIV.
  - Write hi/lo: product {hi,lo}, or lo=quotient and hi=remainder.
  - Return to IDLE and pulse done.
- Divide by zero (src_b=0, signed or unsigned) is a decided result, not a trap:
  - lo=32'hFFFFFFFF and hi=src_a, written at the FIX edge.
  - Latency is the same as a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the 32-bit wrap of the magnitude path.
- Width rules:
  - All magnitude arithmetic is unsigned.
  - |0x80000000| = 0x80000000 is treated as unsigned 2^31.
  - Negation wraps modulo 2^64 for products and 2^32 for quotient/remainder.
- start while busy is ignored. The stall from busy guarantees the instruction is re-presented once IDLE is reached.
- flush has priority over everything except reset.
  - In IDLE, flush blocks start, including MTHI/MTLO.
  - In MUL/DIV/FIX, flush returns the block to IDLE at the next edge with hi/lo unchanged and no done pulse.
- Asynchronous reset mid-operation aborts immediately; all outputs take their reset values.

## Timing
- Edge E0 samples start: busy=1 from E0 until E33.
- E1..E32 perform the 32 iterations; state=FIX during the cycle after E32.
- E33: hi/lo update, busy=0, done=1 for exactly one cycle.
- A dependent MFHI/MFLO can issue the cycle after busy falls.
- MTHI/MTLO: hi/lo are visible the cycle after E0; busy is never asserted.
- busy is a registered state decode with no combinational path from start. The ID-stage stall covers the start cycle by decoding op directly.
- Back-to-back: a new start is accepted in the cycle busy=0, i.e. at E33's following edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy high 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, single done pulse.
- MULT -3 × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 1000 / 7, then flush asserted 10 cycles after start -> busy=0 next cycle, hi/lo keep prior values, no done pulse.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one cycle each, busy never 1. start held during busy is ignored (no restart).
- rst driven low 5 cycles into a MULT -> hi=lo=0, busy=done=0 immediately. After release, a MULTU 2×3 gives lo=6, hi=0.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO for the MIPS EX stage.
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus one sign-fix cycle.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;     // multiplicand, or divisor
    logic [63:0] acc_q, acc_d;         // product; low half holds dividend/quotient
    logic [31:0] rem_q, rem_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_div_q, is_div_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_signed;
    logic [31:0] abs_a, abs_b, mag_a, mag_b;
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        ge;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        is_signed = (op == OP_MULT) || (op == OP_DIV);
        abs_a     = src_a[31] ? (~src_a + 32'd1) : src_a;
        abs_b     = src_b[31] ? (~src_b + 32'd1) : src_b;
        mag_a     = is_signed ? abs_a : src_a;
        mag_b     = is_signed ? abs_b : src_b;

        add_sum   = {1'b0, acc_q[63:32]} + {1'b0, mcand_q};
        shifted   = {rem_q, acc_q[31]};
        ge        = shifted >= {1'b0, mcand_q};
        // True difference is below the divisor whenever ge holds, so 32 bits suffice.
        diff      = shifted[31:0] - mcand_q;

        prod_fix  = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix   = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix   = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
                            neg_res_d = is_signed && (src_a[31] ^ src_b[31]);
                            neg_rem_d = is_signed && src_a[31];
                            dbz_d     = (src_b == 32'd0);
                            cnt_d     = 5'd0;
                            rem_d     = 32'd0;
                            if (is_div_d) begin
                                mcand_d = mag_b;
                                acc_d   = {32'd0, mag_a};
                                state_d = DIV;
                            end else begin
                                mcand_d = mag_a;
                                acc_d   = {32'd0, mag_b};
                                state_d = MUL;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (acc_q[0]) acc_d = {add_sum, acc_q[31:1]};
                else          acc_d = {1'b0, acc_q[63:1]};
                if (cnt_q == 5'd31) begin
                    cnt_d   = 5'd0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DIV: begin
                if (ge) begin
                    rem_d        = diff;
                    acc_d[31:0]  = {acc_q[30:0], 1'b1};
                end else begin
                    rem_d        = shifted[31:0];
                    acc_d[31:0]  = {acc_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd31) begin
                    cnt_d   = 5'd0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    // Zero divisor leaves the dividend in the remainder, so hi already equals src_a.
                    lo_d = dbz_q ? 32'hFFFF_FFFF : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            mcand_q   <= 32'd0;
            acc_q     <= 64'd0;
            rem_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO queued at issue, checked on done.
module tb_ex_muldiv;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] arch = 64'd0;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Issue one mul/div, optionally keep start asserted (with other operands) while busy.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        int n;
        logic [63:0] e;
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        if (hold) begin
            op = OP_DIVU; src_a = 32'd77; src_b = 32'd5;
        end else begin
            start = 1'b0;
        end
        n = 1;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy cycles"}, 64'(n - 1), 64'd33);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        if (done === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " hilo"}, {hi, lo}, e);
            arch = e;
        end
        @(negedge clk);
        check({tag, " done one cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          d0;

        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        rst = 1'b1;

        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult -3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        check("mult -3x5 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div -7/2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu 100/0", OP_DIVU, 32'd100, 32'd0, 1'b0);
        check("divu 100/0 const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("div -100/0", OP_DIV, 32'hFFFF_FF9C, 32'd0, 1'b0);
        run_op("mult minint", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'(1 + $urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op("random", ro, ra, rb, 1'b0);
        end

        // MTHI/MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'h1234_5678;
        @(negedge clk);
        check("mthi hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        check("mthi busy", {63'd0, busy}, 64'd0);
        op = OP_MTLO; src_a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        check("mtlo busy", {63'd0, busy}, 64'd0);
        arch = {hi, lo};

        // flush in IDLE blocks MTHI
        start = 1'b1; flush = 1'b1; op = OP_MTHI; src_a = 32'hAAAA_5555;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle flush hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        check("idle flush busy", {63'd0, busy}, 64'd0);

        run_op("held start", OP_MULTU, 32'd12345, 32'd678, 1'b1);

        // flush mid-divide
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-flush busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        check("flush hilo", {hi, lo}, arch);
        repeat (40) @(negedge clk);
        check("flush no done", 64'(done_cnt), 64'(d0));
        check("flush hilo later", {hi, lo}, arch);

        // async reset mid-MULT
        @(negedge clk);
        start = 1'b1; op = OP_MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst hilo", {hi, lo}, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        arch = 64'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op("multu 2x3", OP_MULTU, 32'd2, 32'd3, 1'b0);
        check("multu 2x3 const", {hi, lo}, 64'd6);
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
